// File: rtl/stream_mux.sv
// Multi-channel stream multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage with valid/ready handshaking.
module stream_mux #(
  parameter  int NUM_CH = 31,
  parameter  int WIDTH  = 2,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [15:0]             xfer_cnt
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  logic             sel_bad;
  int               rr_idx;

  assign load    = !out_valid || out_ready;
  assign sel_bad = (int'(sel) >= NUM_CH);

  // Arbitration: fixed mode looks only at sel, round-robin scans upward from
  // the channel after the last one granted, wrapping at NUM_CH.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        rr_idx = (int'(rr_ptr) + k) % NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!grant_vld && rr_idx == i && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && load && grant_vld;
      end
    end
  end

  // Single output register; a load with no grant drains it but keeps the
  // last data and channel index visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      xfer_cnt  <= 16'd0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else begin
      if (!mode && sel_bad)
        sel_err <= 1'b1;
      if (load) begin
        if (grant_vld) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_ch    <= grant_idx;
          xfer_cnt  <= xfer_cnt + 16'd1;
          if (mode)
            rr_ptr <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed testbench for stream_mux: fixed select, round-robin order,
// backpressure, out-of-range select and mid-operation reset.
module tb_stream_mux;

  localparam int NUM_CH = 31;
  localparam int WIDTH  = 2;
  localparam int SEL_W  = 5;

  logic                    clk;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [15:0]             xfer_cnt;

  int checks;
  int errors;
  int exp_cnt;

  stream_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b1; sel = '0; in_data = '1; in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_data got %b want 00", out_data); end
    checks++; if (out_ch !== 5'd0) begin errors++; $display("[TB] FAIL reset_out_ch got %0d want 0", out_ch); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_err got %b want 0", sel_err); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_xfer_cnt got %0d want 0", xfer_cnt); end
    checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL reset_in_ready got %h want 0", in_ready); end
    tick;
    rst = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0;
    exp_cnt = 0;
  endtask

  task automatic test_fixed_sel5;
    mode = 1'b0; sel = 5'd5; in_data = '0; set_ch(5, 2'b10);
    in_valid = 31'd1 << 5; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== (31'd1 << 5)) begin errors++; $display("[TB] FAIL sel5_in_ready got %h want %h", in_ready, 31'd1 << 5); end
    tick;
    exp_cnt++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sel5_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 2'b10) begin errors++; $display("[TB] FAIL sel5_out_data got %b want 10", out_data); end
    checks++; if (out_ch !== 5'd5) begin errors++; $display("[TB] FAIL sel5_out_ch got %0d want 5", out_ch); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("[TB] FAIL sel5_xfer_cnt got %0d want 1", xfer_cnt); end
    in_valid = '0;
    #1;
    checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL sel5_idle_in_ready got %h want 0", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sel5_drain_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 2'b10 || out_ch !== 5'd5) begin errors++; $display("[TB] FAIL sel5_hold got data %b ch %0d want 10 ch 5", out_data, out_ch); end
  endtask

  task automatic test_fixed_all;
    in_valid = '1; out_ready = 1'b1; mode = 1'b0;
    for (int s = 0; s < NUM_CH; s++) begin
      in_data = '1;
      set_ch(s, 2'b01);
      sel = 5'(s);
      tick;
      exp_cnt++;
      checks++; if (out_data !== 2'b01 || out_ch !== 5'(s) || out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL fixed_sel%0d got data %b ch %0d valid %b want 01 ch %0d valid 1", s, out_data, out_ch, out_valid, s);
      end
    end
    checks++; if (xfer_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL fixed_all_xfer_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_round_robin;
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 2'((i + 1) % 4));
    for (int k = 0; k <= NUM_CH; k++) begin
      tick;
      exp_cnt++;
      checks++; if (out_ch !== 5'(k % NUM_CH) || out_data !== 2'(((k % NUM_CH) + 1) % 4)) begin
        errors++; $display("[TB] FAIL rr_step%0d got ch %0d data %b want ch %0d", k, out_ch, out_data, k % NUM_CH);
      end
    end
    checks++; if (xfer_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL rr_xfer_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL bp_in_ready_initial got %h want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (out_valid !== 1'b1 || out_ch !== 5'd0 || out_data !== 2'b01) begin
        errors++; $display("[TB] FAIL bp_hold%0d got valid %b ch %0d data %b want 1 ch 0 data 01", c, out_valid, out_ch, out_data);
      end
      checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL bp_in_ready%0d got %h want 0", c, in_ready); end
      checks++; if (xfer_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL bp_xfer_cnt%0d got %0d want %0d", c, xfer_cnt, exp_cnt); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== (31'd1 << 1)) begin errors++; $display("[TB] FAIL bp_release_in_ready got %h want %h", in_ready, 31'd1 << 1); end
    tick;
    exp_cnt++;
    checks++; if (out_ch !== 5'd1 || xfer_cnt !== 16'(exp_cnt)) begin
      errors++; $display("[TB] FAIL bp_release got ch %0d cnt %0d want ch 1 cnt %0d", out_ch, xfer_cnt, exp_cnt);
    end
  endtask

  task automatic test_sel_err;
    mode = 1'b0; sel = 5'd31; in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL selerr_in_ready got %h want 0", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL selerr_out_valid got %b want 0", out_valid); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("[TB] FAIL selerr_set got %b want 1", sel_err); end
    sel = 5'd3;
    tick;
    exp_cnt++;
    checks++; if (sel_err !== 1'b1) begin errors++; $display("[TB] FAIL selerr_sticky got %b want 1", sel_err); end
    checks++; if (out_ch !== 5'd3 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL selerr_recover got ch %0d valid %b want ch 3 valid 1", out_ch, out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL selerr_cleared got %b want 0", sel_err); end
    tick;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset_midop;
    mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) tick;
    exp_cnt = 7;
    checks++; if (xfer_cnt !== 16'd7 || out_valid !== 1'b1 || out_ch !== 5'd6) begin
      errors++; $display("[TB] FAIL midop_pre got cnt %0d valid %b ch %0d want 7 1 6", xfer_cnt, out_valid, out_ch);
    end
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 2'b00 || out_ch !== 5'd0 || xfer_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL midop_async got valid %b data %b ch %0d cnt %0d want all 0", out_valid, out_data, out_ch, xfer_cnt);
    end
    checks++; if (in_ready !== 31'd0) begin errors++; $display("[TB] FAIL midop_in_ready got %h want 0", in_ready); end
    #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 31'd1) begin errors++; $display("[TB] FAIL midop_first_grant got %h want 1", in_ready); end
    tick;
    checks++; if (out_ch !== 5'd0 || xfer_cnt !== 16'd1 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midop_first_beat got ch %0d cnt %0d valid %b want 0 1 1", out_ch, xfer_cnt, out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    test_reset;
    test_fixed_sel5;
    test_fixed_all;
    test_round_robin;
    test_backpressure;
    test_sel_err;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL provide parameter NUM_CH, default 31, meaning number of input channels (2..32).
REQ-002 SHALL provide parameter WIDTH, default 2, meaning data bits per channel (1..64).
REQ-003 SHALL provide localparam SEL_W = clog2(NUM_CH), minimum 1, meaning channel index width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL provide port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL provide port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-008 SHALL provide port sel, input, SEL_W bits: channel index used in fixed mode.
REQ-009 SHALL provide port in_data, input, NUM_CH*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL provide port in_valid, input, NUM_CH bits: per-channel valid.
REQ-011 SHALL provide port in_ready, output, NUM_CH bits: per-channel ready, combinational.
REQ-012 SHALL provide port out_data, output, WIDTH bits: registered selected data.
REQ-013 SHALL provide port out_ch, output, SEL_W bits: registered index of the source channel.
REQ-014 SHALL provide port out_valid, output, 1 bit: registered output valid.
REQ-015 SHALL provide port out_ready, input, 1 bit: downstream ready.
REQ-016 SHALL provide port sel_err, output, 1 bit: sticky flag for an out-of-range sel.
REQ-017 SHALL provide port xfer_cnt, output, 16 bits: count of accepted input beats, wrapping.

Function
REQ-018 SHALL define load = !out_valid || out_ready, evaluated every cycle.
REQ-019 SHALL, in mode 0, use grant = sel when sel < NUM_CH and in_valid[sel] = 1; otherwise no grant.
REQ-020 SHALL, in mode 1, grant the first channel with in_valid = 1, searching upward with wrap from rr_ptr+1 modulo NUM_CH.
REQ-021 SHALL, in mode 1, load rr_ptr with the granted index on each accepted beat, and leave it unchanged otherwise.
REQ-022 SHALL drive in_ready[g] = 1 only when load = 1 and channel g is granted; all other in_ready bits SHALL be 0, so at most one bit is high.
REQ-023 SHALL, on an accepted beat (in_valid[g] && in_ready[g]), capture in_data of channel g into out_data and g into out_ch, set out_valid = 1, and increment xfer_cnt.
REQ-024 SHALL, when load = 1 with no grant, clear out_valid to 0 and hold out_data and out_ch.
REQ-025 SHALL hold out_valid, out_data and out_ch stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL have one-cycle latency from input acceptance to out_valid.
REQ-027 SHALL sustain full throughput of one beat per cycle when out_ready is held at 1.
REQ-028 SHALL sample mode and sel combinationally each cycle; a change takes effect on the next grant, and beats already in the output register are not affected.
REQ-029 SHALL keep rr_ptr unchanged while in mode 0.
REQ-030 SHALL set sel_err to 1 on any cycle with mode = 0 and sel >= NUM_CH, and hold it until reset.
REQ-031 SHALL wrap xfer_cnt from 0xFFFF to 0x0000 with no flag.
REQ-032 SHALL perform no internal buffering beyond the single output register.

Reset
REQ-033 SHALL, while rst = 1, asynchronously force out_valid = 0, out_data = 0, out_ch = 0, sel_err = 0, xfer_cnt = 0 and rr_ptr = NUM_CH-1, so channel 0 has first priority.
REQ-034 SHALL drive all in_ready bits to 0 while rst = 1.
REQ-035 SHALL discard any beat held in the output register if reset is asserted mid-operation, with no acceptance on the reset cycle.

Verification
REQ-036 Fixed mode, sel = 5, in_valid[5] = 1, in_data ch5 = 2'b10, out_ready = 1 -> in_ready = 1<<5; the next cycle gives out_valid = 1, out_data = 2'b10, out_ch = 5, xfer_cnt = 1.
REQ-037 Fixed mode, sel = 19, ch19 = 2'b01, ch18 = 2'b11 -> out_data = 2'b01, out_ch = 19; repeat the same check for every sel 0..30.
REQ-038 Round-robin with all 31 channels valid and out_ready = 1 -> out_ch follows the sequence 0, 1, ..., 30, 0 on consecutive cycles.
REQ-039 Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_ch stay stable, in_ready = 0 throughout, and xfer_cnt does not change.
REQ-040 Fixed mode, sel = 31 with NUM_CH = 31 -> no in_ready, out_valid = 0, sel_err = 1 and sticky; after reset, sel_err = 0.
REQ-041 Assert rst while out_valid = 1 and xfer_cnt = 7 -> outputs are immediately 0, and the first grant after reset in round-robin is channel 0.
